// File: rtl/fir_out_decimator.sv
// fir_out_decimator
//   Consumes the unsigned FIR output stream. It keeps every DECIM-th valid
//   sample, rounds it half-up, right-shifts it by SHIFT and saturates it to
//   OUT_W bits. Results are queued in a DEPTH-entry FIFO toward the sink.
//
//   Optional build macro: FIR_DECIM_AVG_EN
//     When defined, a boxcar average of each group of DECIM valid samples is
//     fed to the scale stage instead of the last sample of the group.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   fir_in      IN_W-bit unsigned filtered sample
//   in_valid    fir_in valid this cycle (no upstream backpressure)
//   out_data    head-of-FIFO sample (registered)
//   out_valid   FIFO not empty
//   out_ready   sink accepts out_data when out_valid && out_ready
//   fifo_count  current FIFO occupancy
//   overflow    sticky: a decimated sample was dropped on a full FIFO
//   clr_ovf     synchronous clear of overflow (a same-cycle drop wins)
//
// Handshake: a word moves to the sink on every rising edge where
// out_valid && out_ready are both high; out_data is stable while
// out_valid && !out_ready.
module fir_out_decimator #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 8,
  parameter int DECIM = 4,
  parameter int SHIFT = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [IN_W-1:0]          fir_in,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int PH_W  = (LOG2D > 0) ? LOG2D : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int SUM_W = IN_W + 1;

  localparam logic [SUM_W-1:0] HALF    = SUM_W'(1) << (SHIFT - 1);
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((1 << OUT_W) - 1);

  // ---------------------------------------------------------------------
  // Phase counter: advances on valid samples only, wraps DECIM-1 -> 0.
  // ---------------------------------------------------------------------
  logic [PH_W-1:0] phase;
  logic            last_phase;
  logic            sel;

  assign last_phase = (phase == PH_W'(DECIM - 1));
  assign sel        = in_valid && last_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= last_phase ? '0 : phase + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Value presented to the scale stage.
  // ---------------------------------------------------------------------
  logic [IN_W-1:0] feed;

`ifdef FIR_DECIM_AVG_EN
  localparam int ACC_W = IN_W + LOG2D;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // The sum includes the current sample so the group's average is ready
  // in the same cycle its last sample arrives.
  assign acc_sum = acc + ACC_W'(fir_in);
  assign feed    = IN_W'(acc_sum >> LOG2D);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= last_phase ? '0 : acc_sum;
    end
  end
`else
  assign feed = fir_in;
`endif

  // ---------------------------------------------------------------------
  // Round half-up, shift, saturate. One extra bit keeps the add from
  // wrapping at full-scale input.
  // ---------------------------------------------------------------------
  logic [SUM_W-1:0] rounded;
  logic [SUM_W-1:0] shifted;
  logic [OUT_W-1:0] scaled;

  assign rounded = {1'b0, feed} + HALF;
  assign shifted = rounded >> SHIFT;
  assign scaled  = (shifted > SAT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

  logic             pipe_valid;
  logic [OUT_W-1:0] pipe_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= sel;
      if (sel) begin
        pipe_data <= scaled;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO with one extra pointer bit to tell full from empty.
  // ---------------------------------------------------------------------
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OUT_W-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [AW-1:0]    next_rd_idx;
  logic [OUT_W-1:0] head_next;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = pipe_valid && (!full || pop);
  assign drop  = pipe_valid && full && !pop;

  // out_data is a register holding the entry that will be at the head after
  // this edge. If that slot is being written right now (FIFO empty after the
  // pop), the incoming word is forwarded into the register; out_valid still
  // waits for the write, so there is no bypass of the FIFO latency.
  assign next_rd_idx = rd_ptr[AW-1:0] + AW'(pop);
  assign head_next   = (push && (wr_ptr[AW-1:0] == next_rd_idx)) ? pipe_data
                                                                 : mem[next_rd_idx];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= pipe_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      out_data <= head_next;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign out_valid  = !empty;
  assign fifo_count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator. Two instances share every input: one with
// DECIM=4 and one with DECIM=1. Expected words are queued when samples are
// driven and compared as each instance hands a word to the sink.
module tb_fir_out_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] fir_in;
  logic        in_valid;
  logic        out_ready;
  logic        clr_ovf;

  logic [7:0]  out_data4, out_data1;
  logic        out_valid4, out_valid1;
  logic [3:0]  fifo_count4, fifo_count1;
  logic        overflow4, overflow1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q4[$];
  logic [7:0] exp_q1[$];
  int         phase4;
  int         acc4;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fir_out_decimator #(.IN_W(17), .OUT_W(8), .DECIM(4), .SHIFT(9), .DEPTH(8)) u_dut4 (
    .clock(clk), .reset(rst_n), .fir_in(fir_in), .in_valid(in_valid),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .fifo_count(fifo_count4), .overflow(overflow4), .clr_ovf(clr_ovf)
  );

  fir_out_decimator #(.IN_W(17), .OUT_W(8), .DECIM(1), .SHIFT(9), .DEPTH(8)) u_dut1 (
    .clock(clk), .reset(rst_n), .fir_in(fir_in), .in_valid(in_valid),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .fifo_count(fifo_count1), .overflow(overflow1), .clr_ovf(clr_ovf)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_scale(input int v);
    int r;
    r = (v + 256) / 512;
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  task automatic model_clear();
    exp_q4.delete();
    exp_q1.delete();
    phase4 = 0;
    acc4   = 0;
  endtask

  // ---------------- driver tasks ----------------
  // keep1 says whether the DECIM=1 instance is expected to store the sample.
  task automatic drive(input logic [16:0] v, input logic valid, input logic keep1);
    @(posedge clk); #1;
    fir_in   = v;
    in_valid = valid;
    if (valid) begin
      if (keep1) exp_q1.push_back(model_scale(int'(v)));
      acc4 += int'(v);
      if (phase4 == 3) begin
`ifdef FIR_DECIM_AVG_EN
        exp_q4.push_back(model_scale(acc4 / 4));
`else
        exp_q4.push_back(model_scale(int'(v)));
`endif
        phase4 = 0;
        acc4   = 0;
      end else begin
        phase4++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Let the sink run until both scoreboards are empty, then confirm idle.
  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q4.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q4.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: pending4=%0d pending1=%0d expected 0 and 0",
               name, exp_q4.size(), exp_q1.size());
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid4 !== 1'b0 || out_valid1 !== 1'b0 || fifo_count4 !== 4'd0 || fifo_count1 !== 4'd0) begin
      errors++;
      $display("FAIL %s_drain_idle: valid4=%b valid1=%b count4=%0d count1=%0d expected 0 0 0 0",
               name, out_valid4, out_valid1, fifo_count4, fifo_count1);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n === 1'b1 && out_ready === 1'b1) begin
      if (out_valid4) begin
        checks++;
        if (exp_q4.size() == 0) begin
          errors++;
          $display("FAIL mon4_unexpected: out_data=%0d but no word expected", out_data4);
        end else begin
          e = exp_q4.pop_front();
          if (out_data4 !== e) begin
            errors++;
            $display("FAIL mon4_data: got %0d expected %0d", out_data4, e);
          end
        end
      end
      if (out_valid1) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL mon1_unexpected: out_data=%0d but no word expected", out_data1);
        end else begin
          e = exp_q1.pop_front();
          if (out_data1 !== e) begin
            errors++;
            $display("FAIL mon1_data: got %0d expected %0d", out_data1, e);
          end
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;      // must be ignored while in reset
    fir_in   = 17'd131071;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || out_valid1 !== 1'b0 || out_data4 !== 8'd0 || out_data1 !== 8'd0 ||
        fifo_count4 !== 4'd0 || fifo_count1 !== 4'd0 || overflow4 !== 1'b0 || overflow1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: v4=%b v1=%b d4=%0d d1=%0d c4=%0d c1=%0d o4=%b o1=%b expected all 0",
               out_valid4, out_valid1, out_data4, out_data1, fifo_count4, fifo_count1, overflow4, overflow1);
    end
    in_valid = 1'b0;
    model_clear();
    rst_n = 1'b1;
    idle(3);
    checks++;
    if (fifo_count4 !== 4'd0 || fifo_count1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_ignored_input: count4=%0d count1=%0d expected 0 0", fifo_count4, fifo_count1);
    end
  endtask

  task automatic test_pick_latency();
    int vals[4] = '{768, 767, 1000, 131071};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(17'(vals[i]), 1'b1, 1'b1);
    @(posedge clk); #1;   // 4th sample captured at this edge
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one edge after 4th sample, expected 0", out_valid4);
    end
    @(negedge clk);
    checks++;
    if (out_valid4 !== 1'b1) begin
      errors++;
      $display("FAIL latency_rise: out_valid=%b two edges after 4th sample, expected 1", out_valid4);
    end
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 4; i++) drive(17'(vals[i]), 1'b1, 1'b1);
    idle(1);
    drain("pick");
  endtask

  task automatic test_rounding();
    int vals[5] = '{767, 768, 0, 130815, 130816};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(17'(vals[i]), 1'b1, 1'b1);
    idle(1);
    drain("rounding");
  endtask

  task automatic test_overflow();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) drive(17'(i * 512), 1'b1, (i <= 8));
    idle(4);
    checks++;
    if (fifo_count1 !== 4'd8 || overflow1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: count1=%0d ovf1=%b expected 8 1", fifo_count1, overflow1);
    end
    checks++;
    if (fifo_count4 !== 4'd2 || overflow4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_decim4: count4=%0d ovf4=%b expected 2 0", fifo_count4, overflow4);
    end
    drain("overflow");
    checks++;
    if (overflow1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf1=%b after drain, expected 1", overflow1);
    end
    @(posedge clk); #1; clr_ovf = 1'b1;
    @(posedge clk); #1; clr_ovf = 1'b0;
    checks++;
    if (overflow1 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf1=%b after clr_ovf, expected 0", overflow1);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) drive(17'(i * 1024), 1'b1, 1'b1);
    idle(3);
    checks++;
    if (fifo_count1 !== 4'd8) begin
      errors++;
      $display("FAIL fullpp_fill: count1=%0d expected 8", fifo_count1);
    end
    drive(17'd9 * 17'd1024, 1'b1, 1'b1);
    @(posedge clk); #1;   // pipe register loaded at this edge
    in_valid  = 1'b0;
    out_ready = 1'b1;     // pop coincides with the push on the next edge
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (fifo_count1 !== 4'd8 || overflow1 !== 1'b0) begin
      errors++;
      $display("FAIL fullpp_nodrop: count1=%0d ovf1=%b expected 8 0", fifo_count1, overflow1);
    end
    drain("fullpp");
  endtask

  task automatic test_gappy();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 36; i++)
      drive(17'($urandom_range(0, 131071)), (i % 3 == 0), 1'b1);
    idle(1);
    drain("gappy");
  endtask

  task automatic test_async_reset_avg();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(17'($urandom_range(0, 131071)), 1'b1, 1'b1);
    idle(4);
    checks++;
    if (fifo_count1 !== 4'd5) begin
      errors++;
      $display("FAIL async_prefill: count1=%0d expected 5", fifo_count1);
    end
    #3;                   // mid-cycle, away from any rising edge
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid1 !== 1'b0 || fifo_count1 !== 4'd0 || out_valid4 !== 1'b0 || fifo_count4 !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: v1=%b c1=%0d v4=%b c4=%0d expected 0 0 0 0",
               out_valid1, fifo_count1, out_valid4, fifo_count4);
    end
    model_clear();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(17'd512, 1'b1, 1'b1);
    drive(17'd1024, 1'b1, 1'b1);
    drive(17'd1536, 1'b1, 1'b1);
    drive(17'd2048, 1'b1, 1'b1);
    idle(1);
    drain("group");
  endtask

  initial begin
    rst_n     = 1'b0;
    fir_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_clear();
    test_reset();
    test_pick_latency();
    test_rounding();
    test_overflow();
    test_full_push_pop();
    test_gappy();
    test_async_reset_avg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
